// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK slot, STOP
// on open-drain SDA/SCL, with a valid/ready command port and registered line drives.
module i2c_master_ctrl #(
    parameter int         DIV      = 4,
    parameter logic [6:0] DEF_ADDR = 7'd27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_addr_sel,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    input  logic       sda_in,
    output logic       sda_drive_low,
    output logic       scl_drive_low,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic [7:0] rdata,
    output logic       rdata_valid
);
    localparam int QW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK_A, WR_DATA, ACK_D, RD_DATA, MACK, STOP, DONE
    } state_t;

    state_t        state, state_n;
    logic [QW-1:0] qcnt, qcnt_n;
    logic [1:0]    qtr, qtr_n;
    logic [2:0]    bit_idx, bit_n;
    logic [6:0]    addr_r, addr_n;
    logic          rw_r, rw_n;
    logic [7:0]    wdata_r, wdata_n;
    logic [7:0]    shreg, shreg_n;
    logic          nack_n, rdv_n, sda_n, scl_n;
    logic [7:0]    tx_byte;
    logic          q_last, slot_end, sample_pt;

    assign q_last    = (qcnt == QW'(DIV - 1));
    assign slot_end  = q_last && (qtr == 2'd3);
    assign sample_pt = q_last && (qtr == 2'd2);

    always_comb begin
        state_n = state;
        qcnt_n  = qcnt;
        qtr_n   = qtr;
        bit_n   = bit_idx;
        addr_n  = addr_r;
        rw_n    = rw_r;
        wdata_n = wdata_r;
        shreg_n = shreg;
        nack_n  = nack;
        sda_n   = 1'b0;
        scl_n   = 1'b0;

        if (state != IDLE && state != DONE) begin
            qcnt_n = q_last ? '0 : qcnt + 1'b1;
            if (q_last) qtr_n = qtr + 2'd1;
        end

        case (state)
            IDLE: if (cmd_valid) begin
                addr_n  = cmd_addr_sel ? cmd_addr : DEF_ADDR;
                rw_n    = cmd_rw;
                wdata_n = cmd_wdata;
                nack_n  = 1'b0;
                qcnt_n  = '0;
                qtr_n   = 2'd0;
                bit_n   = 3'd0;
                state_n = START;
            end
            START: if (slot_end) begin
                bit_n   = 3'd0;
                state_n = ADDR;
            end
            ADDR: if (slot_end) begin
                bit_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_n = ACK_A;
            end
            ACK_A: begin
                if (sample_pt && sda_in) nack_n = 1'b1;
                // nack is already registered from the Q2 sample by the slot end
                if (slot_end) begin
                    bit_n   = 3'd0;
                    state_n = nack ? STOP : (rw_r ? RD_DATA : WR_DATA);
                end
            end
            WR_DATA: if (slot_end) begin
                bit_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_n = ACK_D;
            end
            ACK_D: begin
                if (sample_pt && sda_in) nack_n = 1'b1;
                if (slot_end) state_n = STOP;
            end
            RD_DATA: begin
                if (sample_pt) shreg_n = {shreg[6:0], sda_in};
                if (slot_end) begin
                    bit_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = MACK;
                end
            end
            MACK:    if (slot_end) state_n = STOP;
            STOP:    if (slot_end) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Line levels follow the next position so the registered drives line up with it
        tx_byte = (state_n == WR_DATA) ? wdata_n : {addr_n, rw_n};
        case (state_n)
            START: sda_n = qtr_n[1];
            ADDR, WR_DATA: begin
                scl_n = !qtr_n[1];
                sda_n = !tx_byte[3'd7 - bit_n];
            end
            ACK_A, ACK_D, RD_DATA, MACK: scl_n = !qtr_n[1];
            STOP: begin
                scl_n = (qtr_n == 2'd0);
                sda_n = !qtr_n[1];
            end
            default: ;
        endcase

        rdv_n = (state_n == DONE) && rw_n && !nack_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            qcnt          <= '0;
            qtr           <= 2'd0;
            bit_idx       <= 3'd0;
            addr_r        <= 7'd0;
            rw_r          <= 1'b0;
            wdata_r       <= 8'd0;
            shreg         <= 8'd0;
            nack          <= 1'b0;
            rdata         <= 8'd0;
            rdata_valid   <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            cmd_ready     <= 1'b1;
            sda_drive_low <= 1'b0;
            scl_drive_low <= 1'b0;
        end else begin
            state         <= state_n;
            qcnt          <= qcnt_n;
            qtr           <= qtr_n;
            bit_idx       <= bit_n;
            addr_r        <= addr_n;
            rw_r          <= rw_n;
            wdata_r       <= wdata_n;
            shreg         <= shreg_n;
            nack          <= nack_n;
            rdata_valid   <= rdv_n;
            if (rdv_n) rdata <= shreg_n;
            done          <= (state_n == DONE);
            busy          <= (state_n != IDLE);
            cmd_ready     <= (state_n == IDLE);
            sda_drive_low <= sda_n;
            scl_drive_low <= scl_n;
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: behavioural I2C slave at address 0x1B, scoreboard of
// expected results popped on every done pulse, plus bus-protocol and handshake watchers.
module tb_i2c_master_ctrl;
    localparam int P_IDLE = 0, P_ADDR = 1, P_AACK = 2, P_WR = 3, P_DACK = 4, P_RD = 5, P_MACK = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0, cmd_addr_sel = 1'b0, cmd_rw = 1'b0;
    logic [6:0] cmd_addr = 7'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       cmd_ready, sda_drive_low, scl_drive_low, busy, done, nack, rdata_valid;
    logic [7:0] rdata;
    logic       s_low = 1'b0;
    logic       scl_line, sda_line;

    assign scl_line = !scl_drive_low;
    assign sda_line = !(sda_drive_low || s_low);

    i2c_master_ctrl #(.DIV(4), .DEF_ADDR(7'd27)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr_sel(cmd_addr_sel), .cmd_addr(cmd_addr), .cmd_rw(cmd_rw),
        .cmd_wdata(cmd_wdata), .sda_in(sda_line), .sda_drive_low(sda_drive_low),
        .scl_drive_low(scl_drive_low), .busy(busy), .done(done), .nack(nack),
        .rdata(rdata), .rdata_valid(rdata_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       nack;
        logic       rdv;
        logic [7:0] rdata;
        int         lat;
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        logic       chk_wd;
        logic       b2b;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0, errors = 0;
    int         cyc = 0, done_cnt = 0, proto_err = 0, hs_err = 0;
    int         start_cnt = 0, stop_cnt = 0;
    logic       sl_present = 1'b1, sl_dnack = 1'b0;
    logic [7:0] sl_rbyte = 8'h00;
    logic [6:0] rx_addr = 7'd0;
    logic       rx_rw = 1'b0, rx_mack = 1'b0;
    logic [7:0] rx_wdata = 8'd0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic n, input logic v, input logic [7:0] rd, input int lat,
                                input logic [6:0] a, input logic rw, input logic [7:0] wd,
                                input logic cw, input logic b2b);
        exp_t e;
        e.nack = n; e.rdv = v; e.rdata = rd; e.lat = lat; e.addr = a;
        e.rw = rw; e.wdata = wd; e.chk_wd = cw; e.b2b = b2b;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Slave model; also flags START/STOP conditions that appear out of place
    initial begin
        logic cs, cd, ps, pd;
        int   ph, cnt;
        logic in_txn;
        logic [7:0] sh;
        ps = 1'b1; pd = 1'b1; ph = P_IDLE; cnt = 0; in_txn = 1'b0; sh = 8'h00;
        forever begin
            @(negedge clk);
            cs = scl_line;
            cd = sda_line;
            if (!reset) begin
                in_txn = 1'b0; ph = P_IDLE; s_low = 1'b0;
            end else if (ps && cs && pd && !cd) begin
                start_cnt++;
                if (in_txn) proto_err++;
                in_txn = 1'b1; ph = P_ADDR; cnt = 0; sh = 8'h00;
                rx_mack = 1'b0; rx_wdata = 8'h00;
            end else if (ps && cs && !pd && cd) begin
                stop_cnt++;
                if (!in_txn) proto_err++;
                in_txn = 1'b0; ph = P_IDLE; s_low = 1'b0;
            end else if (!ps && cs) begin
                case (ph)
                    P_ADDR, P_WR: begin sh = {sh[6:0], cd}; cnt++; end
                    P_RD:   cnt++;
                    P_MACK: begin rx_mack = cd; ph = P_IDLE; end
                    default: ;
                endcase
            end else if (ps && !cs) begin
                case (ph)
                    P_ADDR: if (cnt == 8) begin
                        rx_addr = sh[7:1];
                        rx_rw   = sh[0];
                        if (sl_present && sh[7:1] == 7'h1B) begin s_low = 1'b1; ph = P_AACK; end
                        else ph = P_IDLE;
                    end
                    P_AACK: begin
                        cnt = 0; sh = 8'h00;
                        if (rx_rw) begin s_low = !sl_rbyte[7]; ph = P_RD; end
                        else begin s_low = 1'b0; ph = P_WR; end
                    end
                    P_WR: if (cnt == 8) begin
                        rx_wdata = sh; s_low = !sl_dnack; ph = P_DACK;
                    end
                    P_DACK: begin s_low = 1'b0; ph = P_IDLE; end
                    P_RD: if (cnt < 8) s_low = !sl_rbyte[7 - cnt];
                          else begin s_low = 1'b0; ph = P_MACK; end
                    default: ;
                endcase
            end
            ps = cs;
            pd = cd;
        end
    end

    // Monitor: pops the scoreboard on each done pulse
    initial begin
        exp_t e;
        int   acc_cyc, start0, stop0, b2b_at;
        logic b2b_pend;
        acc_cyc = 0; start0 = 0; stop0 = 0; b2b_at = 0; b2b_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (cmd_valid && cmd_ready) begin
                    if (b2b_pend) chk("b2b_accept_cycle", cyc, b2b_at);
                    b2b_pend = 1'b0;
                    acc_cyc = cyc; start0 = start_cnt; stop0 = stop_cnt;
                end
                if (busy && cmd_ready) hs_err++;
                if (rdata_valid && !done) hs_err++;
                if (done) begin
                    done_cnt++;
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: at cycle %0d with empty scoreboard", cyc);
                    end else begin
                        e = sbq.pop_front();
                        chk("nack", nack, e.nack);
                        chk("rdata_valid", rdata_valid, e.rdv);
                        chk("rdata", rdata, e.rdata);
                        chk("latency", cyc - acc_cyc + 1, e.lat);
                        chk("slave_addr", rx_addr, e.addr);
                        chk("slave_rw", rx_rw, e.rw);
                        chk("start_count", start_cnt - start0, 1);
                        chk("stop_count", stop_cnt - stop0, 1);
                        if (e.chk_wd) chk("slave_wdata", rx_wdata, e.wdata);
                        if (e.rw && !e.nack) chk("mack_released", rx_mack, 1);
                        if (e.b2b) begin b2b_pend = 1'b1; b2b_at = cyc + 1; end
                    end
                end
            end
        end
    end

    task automatic send(input logic sel, input logic [6:0] a, input logic rw, input logic [7:0] wd,
                        input logic hold, input exp_t e, input logic push);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        cmd_addr_sel = sel; cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_valid = 1'b1;
        if (push) sbq.push_back(e);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1'b1; break; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_timeout: cmd_ready never rose within 2000 cycles");
        end
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 2000 && done_cnt < n; i++) @(posedge clk);
        if (done_cnt < n) begin
            checks++; errors++;
            $display("FAIL done_timeout: done count %0d expected %0d", done_cnt, n);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sda", sda_drive_low, 0);
        chk("rst_scl", scl_drive_low, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nack", nack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rdv", rdata_valid, 0);
        chk("rst_ready", cmd_ready, 1);
        @(posedge clk); #1 reset = 1'b1;

        // write A5 to the default address (0011011_0 then 10100101)
        send(0, 7'h55, 0, 8'hA5, 0, mk(0, 0, 8'h00, 322, 7'h1B, 0, 8'hA5, 1, 0), 1);
        wait_done(1);
        // read 3C from 0x1B
        sl_rbyte = 8'h3C;
        send(1, 7'h1B, 1, 8'h00, 0, mk(0, 1, 8'h3C, 322, 7'h1B, 1, 8'h00, 0, 0), 1);
        wait_done(2);
        // slave absent: address NACK, short transaction, rdata held
        sl_present = 1'b0;
        send(1, 7'h1B, 1, 8'h00, 0, mk(1, 0, 8'h3C, 178, 7'h1B, 1, 8'h00, 0, 0), 1);
        wait_done(3);
        sl_present = 1'b1;
        // wrong address: NACK
        send(1, 7'h50, 0, 8'h11, 0, mk(1, 0, 8'h3C, 178, 7'h50, 0, 8'h00, 0, 0), 1);
        wait_done(4);
        // data NACK: full length, nack set
        sl_dnack = 1'b1;
        send(0, 7'h00, 0, 8'hFF, 0, mk(1, 0, 8'h3C, 322, 7'h1B, 0, 8'hFF, 1, 0), 1);
        wait_done(5);
        sl_dnack = 1'b0;
        // cmd_valid held: second command (fields changed while busy) accepted on first IDLE cycle
        send(0, 7'h2A, 0, 8'h5A, 1, mk(0, 0, 8'h3C, 322, 7'h1B, 0, 8'h5A, 1, 1), 1);
        send(1, 7'h1B, 0, 8'hC3, 0, mk(0, 0, 8'h3C, 322, 7'h1B, 0, 8'hC3, 1, 0), 1);
        wait_done(7);
        // read with both edge bits set
        sl_rbyte = 8'h81;
        send(1, 7'h1B, 1, 8'h00, 0, mk(0, 1, 8'h81, 322, 7'h1B, 1, 8'h00, 0, 0), 1);
        wait_done(8);
        // reset during the 4th data bit (Q1: SCL low, bit4 of E5 = 0 so SDA low)
        send(0, 7'h00, 0, 8'hE5, 0, mk(0, 0, 8'h00, 0, 7'h00, 0, 8'h00, 0, 0), 0);
        repeat (213) @(posedge clk);
        #1;
        chk("pre_rst_scl_low", scl_drive_low, 1);
        chk("pre_rst_sda_low", sda_drive_low, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_sda", sda_drive_low, 0);
        chk("mid_rst_scl", scl_drive_low, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        send(0, 7'h00, 0, 8'h7E, 0, mk(0, 0, 8'h00, 322, 7'h1B, 0, 8'h7E, 1, 0), 1);
        wait_done(9);

        repeat (5) @(posedge clk);
        chk("protocol_errors", proto_err, 0);
        chk("handshake_errors", hs_err, 0);
        chk("scoreboard_left", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
